// File: rtl/ex_mem_stage_latch_if.sv
// EX -> EX/MEM -> MEM boundary signals. The latch is the slave: it consumes EX results
// and produces the MEM-side op, the IF redirect and the perf counters.
interface ex_mem_stage_latch_if #(parameter int CNT_W = 32);
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      PC_out_EX;
  logic [31:0]      PC4_out_EX;
  logic             zero_out_EX;
  logic [31:0]      ALU_out_EX;
  logic [31:0]      Rs2_out_EX;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic             ex_reg_wr;
  logic [1:0]       ex_wb_sel;
  logic [4:0]       ex_rd;
  logic             mem_valid;
  logic             mem_ready;
  logic [31:0]      mem_alu;
  logic [31:0]      mem_pc4;
  logic [31:0]      mem_wdata;
  logic             mem_mem_rd;
  logic             mem_mem_wr;
  logic             mem_reg_wr;
  logic [1:0]       mem_wb_sel;
  logic [4:0]       mem_rd;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] tkn_cnt;

  modport slave (
    input  ex_valid, PC_out_EX, PC4_out_EX, zero_out_EX, ALU_out_EX, Rs2_out_EX,
           ex_branch, ex_jump, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_wb_sel, ex_rd, mem_ready,
    output ex_ready, mem_valid, mem_alu, mem_pc4, mem_wdata, mem_mem_rd, mem_mem_wr,
           mem_reg_wr, mem_wb_sel, mem_rd, redirect_valid, redirect_pc, ret_cnt, tkn_cnt
  );

  modport master (
    output ex_valid, PC_out_EX, PC4_out_EX, zero_out_EX, ALU_out_EX, Rs2_out_EX,
           ex_branch, ex_jump, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_wb_sel, ex_rd, mem_ready,
    input  ex_ready, mem_valid, mem_alu, mem_pc4, mem_wdata, mem_mem_rd, mem_mem_wr,
           mem_reg_wr, mem_wb_sel, mem_rd, redirect_valid, redirect_pc, ret_cnt, tkn_cnt
  );
endinterface

// File: rtl/ex_mem_stage_latch.sv
// EX/MEM pipeline register with valid/ready towards MEM, branch/jump resolution producing a
// one-cycle IF redirect, and retired / taken-branch perf counters.
module ex_mem_stage_latch #(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  ex_mem_stage_latch_if.slave  bus
);

  logic             r_mem_valid;
  logic [31:0]      r_mem_alu;
  logic [31:0]      r_mem_pc4;
  logic [31:0]      r_mem_wdata;
  logic             r_mem_mem_rd;
  logic             r_mem_mem_wr;
  logic             r_mem_reg_wr;
  logic [1:0]       r_mem_wb_sel;
  logic [4:0]       r_mem_rd;
  logic             r_redirect_valid;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_ret_cnt;
  logic [CNT_W-1:0] r_tkn_cnt;

  logic w_ex_ready;
  logic w_acc;
  logic w_taken;
  logic w_retire;

  assign w_ex_ready = ~r_mem_valid | bus.mem_ready;
  // The op arriving in the redirect cycle is wrong-path; drop it instead of latching.
  assign w_acc      = bus.ex_valid & w_ex_ready & ~r_redirect_valid;
  assign w_taken    = w_acc & (bus.ex_jump | (bus.ex_branch & bus.zero_out_EX));
  assign w_retire   = r_mem_valid & bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid  <= 1'b0;
      r_mem_alu    <= '0;
      r_mem_pc4    <= '0;
      r_mem_wdata  <= '0;
      r_mem_mem_rd <= 1'b0;
      r_mem_mem_wr <= 1'b0;
      r_mem_reg_wr <= 1'b0;
      r_mem_wb_sel <= '0;
      r_mem_rd     <= '0;
    end else if (w_acc) begin
      r_mem_valid  <= 1'b1;
      r_mem_alu    <= bus.ALU_out_EX;
      r_mem_pc4    <= bus.PC4_out_EX;
      r_mem_wdata  <= bus.Rs2_out_EX;
      r_mem_mem_rd <= bus.ex_mem_rd;
      r_mem_mem_wr <= bus.ex_mem_wr;
      r_mem_reg_wr <= bus.ex_reg_wr & (bus.ex_rd != 5'd0);
      r_mem_wb_sel <= bus.ex_wb_sel;
      r_mem_rd     <= bus.ex_rd;
    end else if (bus.mem_ready) begin
      r_mem_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_ret_cnt        <= '0;
      r_tkn_cnt        <= '0;
    end else begin
      r_redirect_valid <= w_taken;
      if (w_taken) begin
        r_redirect_pc <= bus.PC_out_EX;
        r_tkn_cnt     <= r_tkn_cnt + CNT_W'(1);
      end
      if (w_retire) r_ret_cnt <= r_ret_cnt + CNT_W'(1);
    end
  end

  assign bus.ex_ready       = w_ex_ready;
  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_alu        = r_mem_alu;
  assign bus.mem_pc4        = r_mem_pc4;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.mem_mem_rd     = r_mem_mem_rd;
  assign bus.mem_mem_wr     = r_mem_mem_wr;
  assign bus.mem_reg_wr     = r_mem_reg_wr;
  assign bus.mem_wb_sel     = r_mem_wb_sel;
  assign bus.mem_rd         = r_mem_rd;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.ret_cnt        = r_ret_cnt;
  assign bus.tkn_cnt        = r_tkn_cnt;

endmodule
